// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared mode encoding and default sizes for the scan decoder
package scan_decoder_pkg;
  typedef enum logic [1:0] {DIRECT = 2'b00, SCAN_UP = 2'b01, SCAN_DOWN = 2'b10, HOLD = 2'b11} mode_t;
  localparam int SEL_W_DEF = 4;
  localparam int NUM_OUT_DEF = 16;
  localparam int DWELL_W_DEF = 8;
endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational index-to-one-hot decoder, zero when disabled or index out of range
module onehot_dec
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_OUT-1:0] oh
);
  localparam logic [SEL_W:0] LIM = (SEL_W + 1)'(NUM_OUT);
  assign oh = (en && {1'b0, idx} < LIM) ? NUM_OUT'(1) << idx : '0;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with direct select, up/down auto-scan and hold modes
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               err
);
  localparam logic [SEL_W:0] LIM = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W:0] LAST = (SEL_W + 1)'(NUM_OUT - 1);
  mode_t m, prev_mode;
  logic [SEL_W-1:0] idx_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic [NUM_OUT-1:0] oh;
  logic wrap_nxt, err_nxt, changed, step, scan, at_top, at_bot, bad_idx, bad_sel;
  assign m = mode_t'(mode);
  assign sel_ready = rst_n && enable && m == DIRECT;
  assign changed = m != prev_mode;
  assign step = cnt >= dwell;
  assign scan = m == SCAN_UP || m == SCAN_DOWN;
  assign at_top = {1'b0, idx} == LAST;
  assign at_bot = idx == '0;
  assign bad_idx = {1'b0, idx} >= LIM;
  assign bad_sel = {1'b0, sel} >= LIM;
  // A mode change restarts the dwell and suppresses the scan step on that edge.
  always_comb begin
    idx_nxt = idx;
    cnt_nxt = cnt;
    wrap_nxt = 1'b0;
    err_nxt = 1'b0;
    if (enable) begin
      if (changed || m == DIRECT) cnt_nxt = '0;
      else if (scan) cnt_nxt = step ? '0 : cnt + 1'b1;
      if (m == DIRECT && sel_valid && sel_ready) begin
        idx_nxt = bad_sel ? idx : sel;
        err_nxt = bad_sel;
      end else if (scan && !changed && step) begin
        if (bad_idx) idx_nxt = '0;
        else if (m == SCAN_UP) begin
          idx_nxt = at_top ? '0 : idx + 1'b1;
          wrap_nxt = at_top;
        end else begin
          idx_nxt = at_bot ? SEL_W'(NUM_OUT - 1) : idx - 1'b1;
          wrap_nxt = at_bot;
        end
      end
    end
  end
  onehot_dec #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_dec (
    .en (enable),
    .idx(idx_nxt),
    .oh (oh)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
      out <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
      prev_mode <= DIRECT;
    end else begin
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      out <= oh;
      wrap <= wrap_nxt;
      err <= err_nxt;
      prev_mode <= m;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: table vectors, corner sequences and random stimulus against a behavioural model
module tb_scan_decoder;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sel_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] sel = '0;
  logic [7:0] dwell = '0;
  logic ready16, wrap16, err16, ready10, wrap10, err10;
  logic [15:0] out16;
  logic [9:0] out10;
  logic [3:0] idx16, idx10;
  int checks = 0, errors = 0;
  int nout[2] = '{16, 10};
  int m_idx[2], m_cnt[2];
  logic [15:0] e_out[2];
  logic e_wrap[2], e_err[2];
  logic [1:0] pmode;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(4), .NUM_OUT(16), .DWELL_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(ready16), .dwell(dwell), .out(out16), .idx(idx16), .wrap(wrap16), .err(err16));
  scan_decoder #(.SEL_W(4), .NUM_OUT(10), .DWELL_W(8)) u10 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(ready10), .dwell(dwell), .out(out10), .idx(idx10), .wrap(wrap10), .err(err10));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0;
      m_cnt[k] = 0;
      e_out[k] = '0;
      e_wrap[k] = 1'b0;
      e_err[k] = 1'b0;
    end
    pmode = 2'b00;
  endtask

  // Position moves around a ring of n slots, one step per dwell+1 cycles spent there.
  task automatic model_step(input int k);
    int n;
    n = nout[k];
    e_wrap[k] = 1'b0;
    e_err[k] = 1'b0;
    if (!enable) begin
      e_out[k] = '0;
      return;
    end
    if (mode == 2'b00) begin
      m_cnt[k] = 0;
      if (sel_valid) begin
        if (int'(sel) < n) m_idx[k] = int'(sel);
        else e_err[k] = 1'b1;
      end
    end else if (mode != pmode) m_cnt[k] = 0;
    else if (mode != 2'b11) begin
      if (m_cnt[k] >= int'(dwell)) begin
        m_cnt[k] = 0;
        e_wrap[k] = (mode == 2'b01) ? (m_idx[k] == n - 1) : (m_idx[k] == 0);
        m_idx[k] = (mode == 2'b01) ? (m_idx[k] + 1) % n : (m_idx[k] + n - 1) % n;
      end else m_cnt[k]++;
    end
    e_out[k] = 16'(1) << m_idx[k];
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    pmode = mode;
    #1;
    chk("idx16", idx16, m_idx[0]);
    chk("out16", out16, e_out[0]);
    chk("wrap16", wrap16, e_wrap[0]);
    chk("err16", err16, e_err[0]);
    chk("ready16", ready16, enable && mode == 2'b00);
    chk("idx10", idx10, m_idx[1]);
    chk("out10", out10, e_out[1]);
    chk("wrap10", wrap10, e_wrap[1]);
    chk("err10", err10, e_err[1]);
    chk("ready10", ready10, enable && mode == 2'b00);
  endtask

  typedef struct {
    logic en;
    logic [1:0] md;
    logic [3:0] s;
    logic sv;
    logic [7:0] dw;
    logic [3:0] x_idx;
    logic [15:0] x_out;
    logic x_wrap;
    logic x_err;
    logic x_ready;
  } vec_t;
  vec_t tbl[22];

  initial begin
    model_reset();
    tbl[0]  = '{1, 2'b00, 4'd5,  1, 8'd0, 4'd5,  16'h0020, 0, 0, 1};
    tbl[1]  = '{1, 2'b00, 4'd9,  0, 8'd0, 4'd5,  16'h0020, 0, 0, 1};
    tbl[2]  = '{1, 2'b00, 4'd14, 1, 8'd0, 4'd14, 16'h4000, 0, 0, 1};
    tbl[3]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd14, 16'h4000, 0, 0, 0};
    tbl[4]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd14, 16'h4000, 0, 0, 0};
    tbl[5]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd14, 16'h4000, 0, 0, 0};
    tbl[6]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd15, 16'h8000, 0, 0, 0};
    tbl[7]  = '{1, 2'b01, 4'd0,  1, 8'd2, 4'd15, 16'h8000, 0, 0, 0};
    tbl[8]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd15, 16'h8000, 0, 0, 0};
    tbl[9]  = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd0,  16'h0001, 1, 0, 0};
    tbl[10] = '{1, 2'b01, 4'd0,  0, 8'd2, 4'd0,  16'h0001, 0, 0, 0};
    tbl[11] = '{1, 2'b00, 4'd0,  0, 8'd0, 4'd0,  16'h0001, 0, 0, 1};
    tbl[12] = '{1, 2'b00, 4'd1,  1, 8'd0, 4'd1,  16'h0002, 0, 0, 1};
    tbl[13] = '{1, 2'b10, 4'd0,  0, 8'd0, 4'd1,  16'h0002, 0, 0, 0};
    tbl[14] = '{1, 2'b10, 4'd0,  0, 8'd0, 4'd0,  16'h0001, 0, 0, 0};
    tbl[15] = '{1, 2'b10, 4'd0,  0, 8'd0, 4'd15, 16'h8000, 1, 0, 0};
    tbl[16] = '{1, 2'b10, 4'd0,  0, 8'd0, 4'd14, 16'h4000, 0, 0, 0};
    tbl[17] = '{1, 2'b11, 4'd3,  1, 8'd0, 4'd14, 16'h4000, 0, 0, 0};
    tbl[18] = '{1, 2'b11, 4'd3,  1, 8'd0, 4'd14, 16'h4000, 0, 0, 0};
    tbl[19] = '{0, 2'b00, 4'd3,  1, 8'd0, 4'd14, 16'h0000, 0, 0, 0};
    tbl[20] = '{1, 2'b00, 4'd3,  0, 8'd0, 4'd14, 16'h4000, 0, 0, 1};
    tbl[21] = '{1, 2'b00, 4'd15, 1, 8'd0, 4'd15, 16'h8000, 0, 0, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out16", out16, 0);
    chk("rst_idx16", idx16, 0);
    chk("rst_wrap16", wrap16, 0);
    chk("rst_err16", err16, 0);
    chk("rst_ready16", ready16, 0);
    chk("rst_ready10", ready10, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      enable = tbl[i].en;
      mode = tbl[i].md;
      sel = tbl[i].s;
      sel_valid = tbl[i].sv;
      dwell = tbl[i].dw;
      tick();
      chk($sformatf("tbl%0d_idx", i), idx16, tbl[i].x_idx);
      chk($sformatf("tbl%0d_out", i), out16, tbl[i].x_out);
      chk($sformatf("tbl%0d_wrap", i), wrap16, tbl[i].x_wrap);
      chk($sformatf("tbl%0d_err", i), err16, tbl[i].x_err);
      chk($sformatf("tbl%0d_ready", i), ready16, tbl[i].x_ready);
    end
    // Illegal select on the 10-output instance.
    enable = 1; mode = 2'b00; sel = 4'd3; sel_valid = 1;
    tick();
    sel = 4'd12;
    tick();
    chk("ill_idx10", idx10, 3);
    chk("ill_err10", err10, 1);
    chk("ill_out10", out10, 10'h008);
    chk("ill_err16", err16, 0);
    sel_valid = 0;
    tick();
    chk("ill_err10_clr", err10, 0);
    chk("ill_out10_hold", out10, 10'h008);
    // Enable dropped mid-scan at idx 7 with one dwell cycle already spent.
    sel = 4'd7; sel_valid = 1;
    tick();
    sel_valid = 0; mode = 2'b01; dwell = 8'd3;
    tick();
    tick();
    enable = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dis_out16", out16, 0);
      chk("dis_idx16", idx16, 7);
    end
    enable = 1;
    tick();
    chk("reen_out16", out16, 16'h0080);
    tick();
    chk("reen_idx16", idx16, 7);
    tick();
    chk("reen_step16", idx16, 8);
    chk("reen_step_out16", out16, 16'h0100);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      enable = $urandom_range(0, 9) != 0;
      sel = 4'($urandom_range(0, 15));
      sel_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) dwell = 8'($urandom_range(0, 3));
      tick();
    end
    // Asynchronous reset between edges while scanning.
    enable = 1; mode = 2'b01; dwell = 8'd0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out16", out16, 0);
    chk("arst_idx16", idx16, 0);
    chk("arst_wrap16", wrap16, 0);
    chk("arst_err16", err16, 0);
    chk("arst_ready16", ready16, 0);
    chk("arst_out10", out10, 0);
    @(negedge clk);
    mode = 2'b00;
    sel_valid = 0;
    #1;
    chk("arst_ready_held", ready16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rel_ready16", ready16, 1);
    sel = 4'd9; sel_valid = 1;
    tick();
    chk("rel_idx16", idx16, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-to-NUM_OUT one-hot decoder. Successor to the fixed 4-to-16 combinational decoder.
- Adds four modes:
  - direct select with a valid/ready handshake;
  - auto-scan up and auto-scan down with a programmable dwell time;
  - hold.
- Adds wrap and error reporting.
- Sits between control logic and one-hot consumers: display digit strobes, row scanning, chip-selects.

Parameters:
- SEL_W, 4, select/index width.
- NUM_OUT, 16, number of one-hot outputs. Legal range 2..2**SEL_W. Indices >= NUM_OUT are illegal.
- DWELL_W, 8, dwell counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  global enable. 0 blanks outputs and freezes state.
- mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- sel  input  SEL_W  requested index (DIRECT mode).
- sel_valid  input  1  sel is valid this cycle.
- sel_ready  output  1  block accepts sel this cycle.
- dwell  input  DWELL_W  cycles-minus-one each scan position is held.
- out  output  NUM_OUT  registered one-hot output.
- idx  output  SEL_W  current index.
- wrap  output  1  one-cycle pulse on scan wrap-around.
- err  output  1  one-cycle pulse on an illegal sel.

Behaviour:
- Reset (async assert, sync release):
  - out=0, idx=0, dwell_cnt=0, wrap=0, err=0.
  - sel_ready=0 while rst_n low.
  - After release, sel_ready follows the combinational rule below.
- sel_ready = enable && (mode==DIRECT). Combinational from enable and mode only; it never depends on sel_valid.
- enable=0:
  - out<=0; idx and dwell_cnt hold; wrap and err <=0.
  - On enable re-assert, out<=onehot(idx) on the next edge.
- All outputs are registered. out always equals onehot(idx) whenever enable was 1 on the previous edge.
- DIRECT, on handshake (sel_valid && sel_ready):
  - Latency 1: next edge idx<=sel, out<=1<<sel.
  - If sel>=NUM_OUT: idx unchanged, out<=onehot(old idx), err<=1 for one cycle.
  - Without a handshake, idx holds. dwell_cnt is held at 0.
- SCAN_UP:
  - dwell_cnt increments each enabled cycle.
  - When dwell_cnt>=dwell: dwell_cnt<=0 and idx<=idx+1.
  - If idx==NUM_OUT-1: idx<=0 and wrap<=1 in the same edge (one cycle only).
  - dwell=0 advances idx every cycle.
  - The >= compare means a dwell reduced mid-count advances on the next edge.
- SCAN_DOWN: mirror of SCAN_UP. idx==0 goes to NUM_OUT-1 with a wrap pulse.
- Scan modes: sel_valid is ignored and err stays 0.
- HOLD: idx, out and dwell_cnt frozen. No pulses.
- Mode change, on any edge where mode differs from the previous cycle's mode:
  - dwell_cnt<=0 and idx is retained.
  - The first advance in the new scan mode occurs dwell+1 cycles later.
- If idx>=NUM_OUT ever occurs (not reachable by design), the next scan step forces idx<=0.
- Width rules:
  - The onehot function zero-extends, then shifts into NUM_OUT bits.
  - Counter arithmetic is unsigned and DWELL_W wide. No overflow is possible because of the >= compare.

Decomposition:
- Shared package scan_decoder_pkg:
  - mode typedef (2-bit enum: DIRECT, SCAN_UP, SCAN_DOWN, HOLD);
  - localparam defaults for SEL_W, NUM_OUT, DWELL_W.
- One natural sub-module: onehot_dec. Combinational, parameterised SEL_W/NUM_OUT, with an enable input. Output is zero for an out-of-range index or when disabled.
- The top holds the mode FSM, dwell counter, index register and output registers.

Test Plan:
- Reset then DIRECT, enable=1:
  - sel=5, sel_valid=1 for one cycle -> next edge idx=5, out=16'h0020.
  - sel_ready=1 throughout.
- NUM_OUT=10, DIRECT, sel=12, sel_valid=1 -> idx stays at its previous value, err=1 for exactly one cycle, out unchanged.
- SCAN_UP, dwell=2, starting idx=14:
  - idx=14 for 3 cycles, 15 for 3 cycles, then 0;
  - wrap=1 only on the edge idx becomes 0;
  - out=16'h0001.
- SCAN_DOWN, dwell=0, from idx=1 -> idx sequence 0, 15, 14, with wrap pulsing on the 0 to 15 edge.
- Toggle enable=0 for 4 cycles mid-SCAN_UP at idx=7, dwell_cnt=1:
  - out=0 and idx=7 held throughout;
  - after re-enable, out=16'h0080 and counting resumes from dwell_cnt=1.
- Assert rst_n=0 mid-scan (async, between edges):
  - out, idx, wrap and err go to 0 immediately, sel_ready=0;
  - after release in DIRECT, sel_ready=1 the next cycle.
